// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register of an in-order integer pipeline.
//             Captures the decoded instruction into the EX stage. It also
//             detects load-use hazards against the instruction currently in
//             EX, inserts a single bubble for each one, and counts the bubbles
//             in a saturating counter.
//  Ports    : clk_i, rst_n_i           clock, async active-low reset
//             id_valid_i, ctrl_i       decode-stage valid and control bundle
//             pc_i, rs*_data_i, imm_i  decode-stage datapath values
//             rs1/rs2/rd_addr_i        register indices
//             funct3_i, funct7b5_i     ALU function fields
//             stall_i, flush_i         downstream stall / redirect kill
//             ex_*_o                   registered EX-stage copies
//             hazard_o                 combinational load-use hazard
//             bubble_cnt_o             saturating count of inserted bubbles
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage #(
  parameter int CTRL_WIDTH = 16,
  parameter int XLEN       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  id_valid_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [4:0]            rs1_addr_i,
  input  logic [4:0]            rs2_addr_i,
  input  logic [4:0]            rd_addr_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7b5_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  output logic [CTRL_WIDTH-1:0] ex_ctrl_o,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic [XLEN-1:0]       ex_rs1_data_o,
  output logic [XLEN-1:0]       ex_rs2_data_o,
  output logic [XLEN-1:0]       ex_imm_o,
  output logic [4:0]            ex_rs1_addr_o,
  output logic [4:0]            ex_rs2_addr_o,
  output logic [4:0]            ex_rd_addr_o,
  output logic [2:0]            ex_funct3_o,
  output logic                  ex_funct7b5_o,
  output logic                  hazard_o,
  output logic [15:0]           bubble_cnt_o
);

  // Control bundle bit positions
  localparam int CB_MEM_WE = 2;
  localparam int CB_MEM_RE = 3;
  localparam int CB_BRANCH = 4;
  localparam int CB_ALUSRC = 5;
  localparam int CB_JAL    = 8;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic                  valid_q,    valid_d;
  logic [CTRL_WIDTH-1:0] ctrl_q,     ctrl_d;
  logic [XLEN-1:0]       pc_q,       pc_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]       imm_q,      imm_d;
  logic [4:0]            rs1_addr_q, rs1_addr_d;
  logic [4:0]            rs2_addr_q, rs2_addr_d;
  logic [4:0]            rd_addr_q,  rd_addr_d;
  logic [2:0]            funct3_q,   funct3_d;
  logic                  funct7b5_q, funct7b5_d;
  logic [15:0]           bubble_cnt_q, bubble_cnt_d;

  logic w_rs1_used;
  logic w_rs2_used;
  logic w_ex_is_load;
  logic w_hazard;

  // jal has no rs1 source; rs2 is read by reg-reg ALU ops, stores and branches.
  assign w_rs1_used   = id_valid_i & ~ctrl_i[CB_JAL];
  assign w_rs2_used   = id_valid_i & (ctrl_i[CB_ALUSRC] | ctrl_i[CB_MEM_WE] |
                                      ctrl_i[CB_BRANCH]);
  // x0 is never a real destination, so a load to x0 cannot cause a stall.
  assign w_ex_is_load = valid_q & ctrl_q[CB_MEM_RE] & (rd_addr_q != 5'd0);

  // A redirect kills the decode instruction anyway, so holding upstream for it
  // would only waste a cycle.
  assign w_hazard = ~flush_i & w_ex_is_load &
                    ((w_rs1_used & (rs1_addr_i == rd_addr_q)) |
                     (w_rs2_used & (rs2_addr_i == rd_addr_q)));

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    rd_addr_d    = rd_addr_q;
    funct3_d     = funct3_q;
    funct7b5_d   = funct7b5_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush_i) begin
      // Datapath holds; only valid/ctrl must be cleared so the kill is safe.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (stall_i) begin
      // Everything holds (defaults above).
    end else if (w_hazard) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
    end else begin
      valid_d    = id_valid_i;
      ctrl_d     = id_valid_i ? ctrl_i : '0;
      pc_d       = pc_i;
      rs1_data_d = rs1_data_i;
      rs2_data_d = rs2_data_i;
      imm_d      = imm_i;
      rs1_addr_d = rs1_addr_i;
      rs2_addr_d = rs2_addr_i;
      rd_addr_d  = rd_addr_i;
      funct3_d   = funct3_i;
      funct7b5_d = funct7b5_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      funct3_q     <= '0;
      funct7b5_q   <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rd_addr_q    <= rd_addr_d;
      funct3_q     <= funct3_d;
      funct7b5_q   <= funct7b5_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_ctrl_o     = ctrl_q;
  assign ex_pc_o       = pc_q;
  assign ex_rs1_data_o = rs1_data_q;
  assign ex_rs2_data_o = rs2_data_q;
  assign ex_imm_o      = imm_q;
  assign ex_rs1_addr_o = rs1_addr_q;
  assign ex_rs2_addr_o = rs2_addr_q;
  assign ex_rd_addr_o  = rd_addr_q;
  assign ex_funct3_o   = funct3_q;
  assign ex_funct7b5_o = funct7b5_q;
  assign hazard_o      = w_hazard;
  assign bubble_cnt_o  = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Purpose  : Self-checking bench for id_ex_stage: a directed vector table
//             plus hand-written stall, reset and counter-saturation sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [15:0] ctrl = '0;
  logic [31:0] pc = '0, rs1d = '0, rs2d = '0, imm = '0;
  logic [4:0]  a1 = '0, a2 = '0, rd = '0;
  logic [2:0]  f3 = '0;
  logic        f7 = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;

  logic        ex_valid;
  logic [15:0] ex_ctrl;
  logic [31:0] ex_pc, ex_rs1d, ex_rs2d, ex_imm;
  logic [4:0]  ex_a1, ex_a2, ex_rd;
  logic [2:0]  ex_f3;
  logic        ex_f7;
  logic        hazard;
  logic [15:0] bcnt;

  int n_vec = 0;
  int n_err = 0;

  // expected EX datapath contents (updated whenever a load is expected)
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_a1, m_a2, m_rd;
  logic [2:0]  m_f3;
  logic        m_f7;

  id_ex_stage #(.CTRL_WIDTH(16), .XLEN(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_valid_i(id_valid), .ctrl_i(ctrl),
    .pc_i(pc), .rs1_data_i(rs1d), .rs2_data_i(rs2d), .imm_i(imm),
    .rs1_addr_i(a1), .rs2_addr_i(a2), .rd_addr_i(rd),
    .funct3_i(f3), .funct7b5_i(f7),
    .stall_i(stall), .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_ctrl_o(ex_ctrl),
    .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1d), .ex_rs2_data_o(ex_rs2d),
    .ex_imm_o(ex_imm),
    .ex_rs1_addr_o(ex_a1), .ex_rs2_addr_o(ex_a2), .ex_rd_addr_o(ex_rd),
    .ex_funct3_o(ex_f3), .ex_funct7b5_o(ex_f7),
    .hazard_o(hazard), .bubble_cnt_o(bcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] ctrl;
    logic [4:0]  a1, a2, rd;
    logic        st, fl;
    logic        e_haz, e_v;
    logic [15:0] e_ctrl, e_cnt;
    int          dpm;   // 0: datapath not checked, 1: loaded from inputs, 2: held
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [15:0] c, logic [4:0] x1, logic [4:0] x2,
                              logic [4:0] xd, logic st, logic fl, logic eh, logic ev,
                              logic [15:0] ec, logic [15:0] en, int dm);
    vec_t t;
    t.v = v; t.ctrl = c; t.a1 = x1; t.a2 = x2; t.rd = xd; t.st = st; t.fl = fl;
    t.e_haz = eh; t.e_v = ev; t.e_ctrl = ec; t.e_cnt = en; t.dpm = dm;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Datapath values derived from a sequence index so every cycle differs.
  task automatic drive(input logic v, input logic [15:0] c, input logic [4:0] x1,
                       input logic [4:0] x2, input logic [4:0] xd, input int idx);
    id_valid = v; ctrl = c; a1 = x1; a2 = x2; rd = xd;
    pc   = 32'h100 + 32'(idx) * 4;
    rs1d = 32'hA000_0000 | 32'(idx);
    rs2d = 32'hB000_0000 | 32'(idx);
    imm  = 32'hFFFF_F000 | 32'(idx);
    f3   = 3'(idx);
    f7   = idx[0];
  endtask

  task automatic capture_model();
    m_pc = pc; m_rs1d = rs1d; m_rs2d = rs2d; m_imm = imm;
    m_a1 = a1; m_a2 = a2; m_rd = rd; m_f3 = f3; m_f7 = f7;
  endtask

  task automatic chk_dp(input string tag);
    chk({tag, ".pc"},   ex_pc,   m_pc);
    chk({tag, ".rs1d"}, ex_rs1d, m_rs1d);
    chk({tag, ".rs2d"}, ex_rs2d, m_rs2d);
    chk({tag, ".imm"},  ex_imm,  m_imm);
    chk({tag, ".a1"},   32'(ex_a1), 32'(m_a1));
    chk({tag, ".a2"},   32'(ex_a2), 32'(m_a2));
    chk({tag, ".rd"},   32'(ex_rd), 32'(m_rd));
    chk({tag, ".f3"},   32'(ex_f3), 32'(m_f3));
    chk({tag, ".f7"},   32'(ex_f7), 32'(m_f7));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
    chk({tag, ".ctrl"},  32'(ex_ctrl),  32'd0);
    chk({tag, ".pc"},    ex_pc,   32'd0);
    chk({tag, ".rs1d"},  ex_rs1d, 32'd0);
    chk({tag, ".rs2d"},  ex_rs2d, 32'd0);
    chk({tag, ".imm"},   ex_imm,  32'd0);
    chk({tag, ".addr"},  {17'd0, ex_a1, ex_a2, ex_rd}, 32'd0);
    chk({tag, ".funct"}, {28'd0, ex_f3, ex_f7}, 32'd0);
    chk({tag, ".cnt"},   32'(bcnt), 32'd0);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {v, ctrl, rs1, rs2, rd, stall, flush, exp hazard, exp valid, exp ctrl, exp cnt, dp}
    tbl.push_back(mk(1, 16'h0003, 1, 2, 5,  0, 0, 0, 1, 16'h0003, 0, 1)); // 0 first load
    tbl.push_back(mk(1, 16'h000B, 1, 2, 7,  0, 0, 0, 1, 16'h000B, 0, 1)); // 1 load rd7
    tbl.push_back(mk(1, 16'h00A2, 3, 7, 8,  0, 0, 1, 0, 16'h0000, 1, 0)); // 2 R-type rs2 use
    tbl.push_back(mk(1, 16'h00A2, 3, 7, 8,  0, 0, 0, 1, 16'h00A2, 1, 1)); // 3 R-type enters
    tbl.push_back(mk(1, 16'h000B, 1, 2, 0,  0, 0, 0, 1, 16'h000B, 1, 1)); // 4 load rd0
    tbl.push_back(mk(1, 16'h00A2, 0, 0, 9,  0, 0, 0, 1, 16'h00A2, 1, 1)); // 5 no hazard on x0
    tbl.push_back(mk(1, 16'h000B, 1, 2, 7,  0, 0, 0, 1, 16'h000B, 1, 1)); // 6 load rd7
    tbl.push_back(mk(1, 16'h0002, 4, 7, 10, 0, 0, 0, 1, 16'h0002, 1, 1)); // 7 I-type rs2==rd
    tbl.push_back(mk(1, 16'h000B, 1, 2, 6,  0, 0, 0, 1, 16'h000B, 1, 1)); // 8 load rd6
    tbl.push_back(mk(1, 16'h0102, 6, 6, 1,  0, 0, 0, 1, 16'h0102, 1, 1)); // 9 jal: no sources
    tbl.push_back(mk(1, 16'h000B, 1, 2, 6,  0, 0, 0, 1, 16'h000B, 1, 1)); // 10 load rd6
    tbl.push_back(mk(1, 16'h0002, 6, 0, 11, 0, 0, 1, 0, 16'h0000, 2, 0)); // 11 rs1 hazard
    tbl.push_back(mk(1, 16'h0002, 6, 0, 11, 0, 0, 0, 1, 16'h0002, 2, 1)); // 12
    tbl.push_back(mk(1, 16'h000B, 1, 2, 12, 0, 0, 0, 1, 16'h000B, 2, 1)); // 13 load rd12
    tbl.push_back(mk(1, 16'h0004, 1, 12, 0, 0, 0, 1, 0, 16'h0000, 3, 0)); // 14 store rs2 hazard
    tbl.push_back(mk(1, 16'h0004, 1, 12, 0, 0, 0, 0, 1, 16'h0004, 3, 1)); // 15
    tbl.push_back(mk(1, 16'h000B, 1, 2, 5,  0, 0, 0, 1, 16'h000B, 3, 1)); // 16 load rd5
    tbl.push_back(mk(0, 16'h00A2, 3, 5, 8,  0, 0, 0, 0, 16'h0000, 3, 1)); // 17 invalid decode
    tbl.push_back(mk(1, 16'hFE03, 1, 2, 4,  0, 0, 0, 1, 16'hFE03, 3, 1)); // 18 reserved bits
    tbl.push_back(mk(1, 16'h000B, 1, 2, 9,  0, 0, 0, 1, 16'h000B, 3, 1)); // 19 load rd9
    tbl.push_back(mk(1, 16'h00A2, 9, 2, 8,  1, 1, 0, 0, 16'h0000, 3, 0)); // 20 flush+stall+haz
    tbl.push_back(mk(1, 16'h000B, 1, 2, 9,  0, 0, 0, 1, 16'h000B, 3, 1)); // 21 load rd9
    tbl.push_back(mk(1, 16'h00A2, 9, 2, 8,  0, 1, 0, 0, 16'h0000, 3, 0)); // 22 flush+haz
    tbl.push_back(mk(1, 16'h000B, 1, 2, 9,  0, 0, 0, 1, 16'h000B, 3, 1)); // 23 load rd9
    tbl.push_back(mk(1, 16'h00A2, 9, 2, 8,  1, 0, 1, 1, 16'h000B, 3, 2)); // 24 stall over haz
    tbl.push_back(mk(1, 16'h00A2, 9, 2, 8,  0, 0, 1, 0, 16'h0000, 4, 0)); // 25 bubble
    tbl.push_back(mk(1, 16'h00A2, 9, 2, 8,  0, 0, 0, 1, 16'h00A2, 4, 1)); // 26
    tbl.push_back(mk(1, 16'h000B, 1, 2, 13, 0, 0, 0, 1, 16'h000B, 4, 1)); // 27 load rd13
    tbl.push_back(mk(1, 16'h0010, 1, 13, 0, 0, 0, 1, 0, 16'h0000, 5, 0)); // 28 branch haz
    tbl.push_back(mk(1, 16'h0010, 1, 13, 0, 0, 0, 0, 1, 16'h0010, 5, 1)); // 29

    // ---- reset state ----
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #2;

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(tbl[i].v, tbl[i].ctrl, tbl[i].a1, tbl[i].a2, tbl[i].rd, i);
      stall = tbl[i].st;
      flush = tbl[i].fl;
      #1;
      chk({tag, ".hazard"}, 32'(hazard), 32'(tbl[i].e_haz));
      if (tbl[i].dpm == 1) capture_model();
      edge_step();
      chk({tag, ".valid"}, 32'(ex_valid), 32'(tbl[i].e_v));
      chk({tag, ".ctrl"},  32'(ex_ctrl),  32'(tbl[i].e_ctrl));
      chk({tag, ".cnt"},   32'(bcnt),     32'(tbl[i].e_cnt));
      if (tbl[i].dpm != 0) chk_dp(tag);
    end
    stall = 1'b0; flush = 1'b0;

    // ---- stall for 3 cycles with changing inputs: everything holds ----
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h00A2 + 16'(k), 5'(k + 2), 5'(k + 3), 5'(k + 20), 100 + k);
      edge_step();
      chk($sformatf("stall%0d.valid", k), 32'(ex_valid), 32'd1);
      chk($sformatf("stall%0d.ctrl", k),  32'(ex_ctrl),  32'h0010);
      chk($sformatf("stall%0d.cnt", k),   32'(bcnt),     32'd5);
      chk_dp($sformatf("stall%0d", k));
    end

    // ---- async reset mid-stall with valid EX: outputs clear before any edge ----
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_stall");
    stall = 1'b0;
    drive(1'b1, 16'h0003, 5'd1, 5'd2, 5'd5, 200);
    capture_model();
    #1;
    rst_n = 1'b1;
    edge_step();
    chk("post_rst.valid", 32'(ex_valid), 32'd1);
    chk("post_rst.ctrl",  32'(ex_ctrl),  32'h0003);
    chk("post_rst.cnt",   32'(bcnt),     32'd0);
    chk_dp("post_rst");

    // ---- async reset mid-hazard: held instruction discarded ----
    drive(1'b1, 16'h000B, 5'd1, 5'd2, 5'd7, 201);
    edge_step();
    drive(1'b1, 16'h00A2, 5'd3, 5'd7, 5'd8, 202);
    #1;
    chk("rst_haz.pre_hazard", 32'(hazard), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_haz.hazard", 32'(hazard), 32'd0);
    chk_zero("rst_haz");
    #1;
    rst_n = 1'b1;
    capture_model();
    edge_step();
    chk("post_rst_haz.valid", 32'(ex_valid), 32'd1);
    chk("post_rst_haz.ctrl",  32'(ex_ctrl),  32'h00A2);
    chk("post_rst_haz.cnt",   32'(bcnt),     32'd0);
    chk_dp("post_rst_haz");

    // ---- counter saturation: preset near the top, then keep bubbling ----
    drive(1'b1, 16'h000B, 5'd1, 5'd2, 5'd7, 300);
    edge_step();
    force dut.bubble_cnt_q = 16'hFFFE;
    #1;
    release dut.bubble_cnt_q;
    #1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 16'h00A2, 5'd3, 5'd7, 5'd8, 301 + k);
      #1;
      chk($sformatf("sat%0d.hazard", k), 32'(hazard), 32'd1);
      edge_step();
      chk($sformatf("sat%0d.valid", k), 32'(ex_valid), 32'd0);
      chk($sformatf("sat%0d.cnt", k),   32'(bcnt),     32'hFFFF);
      drive(1'b1, 16'h000B, 5'd1, 5'd2, 5'd7, 310 + k);
      edge_step();
      chk($sformatf("sat%0d.reload", k), 32'(ex_ctrl), 32'h000B);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything beyond this is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: CTRL_WIDTH, 16, width of decoded control bundle.
REQ-002 Parameter: XLEN, 32, datapath width.
REQ-003 clk_i  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 id_valid_i  in  1  decode stage holds a valid instruction.
REQ-006 ctrl_i  in  CTRL_WIDTH  decoded control bundle: [0] is_mem_to_reg, [1] reg_wr_en, [2] mem_we, [3] mem_re, [4] is_branch, [5] alusrc (1=reg), [7:6] aluop, [8] is_jal, [15:9] reserved zero.
REQ-007 pc_i, rs1_data_i, rs2_data_i, imm_i  in  XLEN each  decode-stage PC, register operands, sign-extended immediate.
REQ-008 rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  register indices.
REQ-009 funct3_i  in  3; funct7b5_i  in  1  ALU function fields.
REQ-010 stall_i  in  1  downstream stall; hold all registered state.
REQ-011 flush_i  in  1  redirect (taken branch/jump); kill the instruction entering EX.
REQ-012 ex_valid_o  out  1; ex_ctrl_o  out  CTRL_WIDTH; ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN; ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  out  5; ex_funct3_o  out  3; ex_funct7b5_o  out  1  -- registered EX-stage copies.
REQ-013 hazard_o  out  1  combinational load-use hazard; upstream (PC, IF/ID) holds while high.
REQ-014 bubble_cnt_o  out  16  registered count of inserted load-use bubbles.

Function
REQ-015 Usage qualifiers: rs1 used when id_valid_i and not ctrl_i[8]; rs2 used when id_valid_i and (ctrl_i[5] or ctrl_i[2] or ctrl_i[4]).
REQ-016 hazard_o SHALL be 1 iff ex_valid_o, ex_ctrl_o[3], ex_rd_addr_o != 0, and (rs1 used and rs1_addr_i == ex_rd_addr_o, or rs2 used and rs2_addr_i == ex_rd_addr_o); otherwise 0.
REQ-017 hazard_o SHALL be forced 0 while flush_i is 1.
REQ-018 Per edge, priority flush_i > stall_i > hazard_o > load.
REQ-019 flush_i=1: ex_valid_o<=0, ex_ctrl_o<=0; datapath registers don't-care (hold acceptable); counter unchanged.
REQ-020 stall_i=1 (flush_i=0): all registers including counter hold.
REQ-021 hazard_o=1 (no flush/stall): bubble inserted -- ex_valid_o<=0, ex_ctrl_o<=0; bubble_cnt_o increments by 1, saturating at 16'hFFFF.
REQ-022 Otherwise load: ex_valid_o<=id_valid_i; ex_ctrl_o<=ctrl_i if id_valid_i else 0; all other outputs <= corresponding inputs.
REQ-023 Latency: one cycle from decode inputs to EX outputs; a hazard costs exactly one bubble, since the load leaves EX on the following edge.
REQ-024 ex_ctrl_o SHALL be zero whenever ex_valid_o is 0, so no write enable reaches memory or regfile from a bubble.
REQ-025 Reserved ctrl bits [15:9] pass through unmodified when loaded.

Reset
REQ-026 On rst_n_i=0, immediately and independent of clk_i: ex_valid_o=0, ex_ctrl_o=0, all data/address/funct outputs=0, bubble_cnt_o=0.
REQ-027 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction; first edge after deassertion performs a normal REQ-018 evaluation.

Verification
REQ-028 Reset then load: id_valid_i=1, ctrl_i=16'h0003, pc_i=32'h100, rd=5 -> after one edge ex_valid_o=1, ex_ctrl_o=16'h0003, ex_pc_o=32'h100, ex_rd_addr_o=5.
REQ-029 Load-use: EX holds load rd=7 (ctrl 16'h000B); decode R-type rs2=7 (ctrl 16'h00A2) -> hazard_o=1; next edge ex_valid_o=0, ex_ctrl_o=0, bubble_cnt_o=1; following edge R-type enters EX, hazard_o=0.
REQ-030 No false hazard: EX load rd=0, or decode I-type (alusrc=0) with rs2_addr_i==rd -> hazard_o=0, no bubble.
REQ-031 Simultaneous flush_i=1, stall_i=1, hazard condition true -> hazard_o=0; next edge ex_valid_o=0, ex_ctrl_o=0, bubble_cnt_o unchanged.
REQ-032 stall_i=1 for 3 cycles with changing inputs -> all outputs constant; bubble_cnt_o preset to 16'hFFFF via repeated hazards -> stays 16'hFFFF on further bubble.
REQ-033 Assert rst_n_i=0 between edges while ex_valid_o=1 -> outputs zero immediately, before next clk_i edge.
